// File: rtl/tensor_core_pkg.sv
// tensor_core_pkg: shared types and constants for the SRAM read streamer
package tensor_core_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int STALL_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} streamer_state_e;
  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
  typedef logic [DATA_WIDTH_DEF-1:0] data_t;
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO with occupancy count, push and pop allowed in the same cycle
module stream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem_q[rd_q];
  assign count = count_q;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  // storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop) rd_q <= nxt(rd_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/sram_read_streamer.sv
// sram_read_streamer: burst SRAM reader emitting words as a valid/ready stream; optional stall counter under SRAM_STREAMER_STATS_EN
module sram_read_streamer
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_base,
  input  logic [ADDR_WIDTH:0]    req_len,
  output logic                   mem_cs,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_dout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,
  output logic                   done,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  streamer_state_e state_q;
  logic [ADDR_WIDTH-1:0] cur_q, mem_addr_q;
  logic [ADDR_WIDTH:0] rem_q;
  logic mem_cs_q, cs_last_q, inflight_q, inflight_last_q, done_q;
  logic [CW-1:0] fifo_count;
  logic [CW:0] occ;
  logic fifo_empty, fifo_full;
  logic [DATA_WIDTH:0] fifo_rdata;
  logic accept, credit, pop;
  // credit uses only registered occupancy so out_ready never reaches mem_cs combinationally
  always_comb begin
    accept = req_valid && state_q == IDLE;
    occ = {1'b0, fifo_count} + {{CW{1'b0}}, mem_cs_q} + {{CW{1'b0}}, inflight_q};
    credit = !fifo_full && occ < (CW + 1)'(FIFO_DEPTH);
    pop = out_valid && out_ready;
  end
  // burst FSM: the accepting edge already issues the first read, so mem_cs rises the cycle after accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q <= '0;
      rem_q <= '0;
      mem_cs_q <= 1'b0;
      mem_addr_q <= '0;
      cs_last_q <= 1'b0;
      inflight_q <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mem_cs_q <= 1'b0;
      cs_last_q <= 1'b0;
      done_q <= 1'b0;
      inflight_q <= mem_cs_q;
      inflight_last_q <= cs_last_q;
      case (state_q)
        IDLE: if (accept) begin
          if (req_len == '0) done_q <= 1'b1;
          else begin
            mem_cs_q <= 1'b1;
            mem_addr_q <= req_base;
            cur_q <= req_base + 1'b1;
            rem_q <= req_len - 1'b1;
            cs_last_q <= req_len == (ADDR_WIDTH + 1)'(1);
            state_q <= req_len == (ADDR_WIDTH + 1)'(1) ? DRAIN : ISSUE;
          end
        end
        ISSUE: if (credit) begin
          mem_cs_q <= 1'b1;
          mem_addr_q <= cur_q;
          cur_q <= cur_q + 1'b1;
          rem_q <= rem_q - 1'b1;
          cs_last_q <= rem_q == (ADDR_WIDTH + 1)'(1);
          if (rem_q == (ADDR_WIDTH + 1)'(1)) state_q <= DRAIN;
        end
        DRAIN: if (pop && out_last) begin
          done_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  stream_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight_q),
    .pop(pop),
    .wdata({inflight_last_q, mem_dout}),
    .rdata(fifo_rdata),
    .count(fifo_count),
    .empty(fifo_empty),
    .full(fifo_full)
  );
  assign req_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign mem_cs = mem_cs_q;
  assign mem_we = 1'b0;
  assign mem_addr = mem_addr_q;
  assign done = done_q;
  assign out_valid = !fifo_empty;
  assign out_data = out_valid ? fifo_rdata[DATA_WIDTH-1:0] : '0;
  assign out_last = out_valid && fifo_rdata[DATA_WIDTH];
`ifdef SRAM_STREAMER_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q;
  // backpressure cycles of the current burst, saturating
  always_ff @(posedge clk) begin
    if (rst || accept) stall_q <= '0;
    else if (out_valid && !out_ready) stall_q <= sat_inc(stall_q);
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule
